// File: rtl/ula_issue.sv
// Single-issue register bank and issue controller feeding the ULA.
// IDLE -> READ -> EXEC (ALU_LAT cycles) -> WB, one instruction at a time.
module ula_issue #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic        CLOCK_27,
   input  logic        RST,
   input  logic [11:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [2:0]  alu_op,
   output logic [2:0]  alu_a,
   output logic [2:0]  alu_b,
   input  logic [3:0]  alu_result,
   output logic        done,
   output logic        ovf,
   output logic        dz,
   input  logic [2:0]  dbg_sel,
   output logic [2:0]  dbg_data
);

   localparam logic [2:0] LAT = 3'(ALU_LAT);
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_LDI = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB
   } state_t;

   state_t      r_state;
   logic [11:0] r_instr;
   logic [2:0]  r_regs [8];
   logic [2:0]  r_cnt;
   logic [2:0]  r_alu_op;
   logic [2:0]  r_alu_a;
   logic [2:0]  r_alu_b;
   logic        r_done;
   logic        r_ovf;
   logic        r_dz;

   logic [2:0]  w_op;
   logic [2:0]  w_rd;
   logic [2:0]  w_ra;
   logic [2:0]  w_rb;
   logic        w_div0;
   logic [3:0]  w_wb;

   assign w_op = r_instr[11:9];
   assign w_rd = r_instr[8:6];
   assign w_ra = r_instr[5:3];
   assign w_rb = r_instr[2:0];

   // Divisor is the registered operand B, i.e. reg[rb] as read.
   assign w_div0 = (w_op == OP_DIV) && (r_alu_b == 3'd0);

   always_comb begin
      w_wb = alu_result;
      if (w_op == OP_LDI)
         w_wb = {1'b0, w_ra};
      else if (w_div0)
         w_wb = 4'b0111;
   end

   always_ff @(posedge CLOCK_27 or posedge RST) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_instr  <= '0;
         r_cnt    <= '0;
         r_alu_op <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         for (int i = 0; i < 8; i++)
            r_regs[i] <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_instr <= instr;
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               r_alu_op <= w_op;
               r_alu_a  <= r_regs[w_ra];
               r_alu_b  <= r_regs[w_rb];
               r_cnt    <= LAT;
               r_state  <= S_EXEC;
            end
            S_EXEC: begin
               if (r_cnt <= 3'd1)
                  r_state <= S_WB;
               else
                  r_cnt <= r_cnt - 3'd1;
            end
            S_WB: begin
               r_regs[w_rd] <= w_wb[2:0];
               r_ovf        <= w_wb[3];
               r_dz         <= w_div0;
               r_done       <= 1'b1;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign instr_ready = (r_state == S_IDLE);
   assign alu_op      = r_alu_op;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign done        = r_done;
   assign ovf         = r_ovf;
   assign dz          = r_dz;
   assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue: two instances (ALU_LAT=1 and 3) driven
// by a behavioural ULA; expectations are hand-computed constants.
module tb_ula_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] instr [2];
   logic        vld   [2];
   logic [2:0]  dsel  [2];
   logic        rdy   [2];
   logic [2:0]  aop   [2];
   logic [2:0]  aa    [2];
   logic [2:0]  ab    [2];
   logic [3:0]  ares  [2];
   logic        dn    [2];
   logic        ov    [2];
   logic        dzz   [2];
   logic [2:0]  ddat  [2];

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Behavioural ULA; divide by zero returns 4'hF so the DUT must ignore it.
   function automatic logic [3:0] ula(input logic [2:0] op,
                                      input logic [2:0] a,
                                      input logic [2:0] b);
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] p;
      x = {1'b0, a};
      y = {1'b0, b};
      p = {4'd0, x} * {4'd0, y};
      case (op)
         3'd0:    return x + y;
         3'd1:    return x - y;
         3'd2:    return p[3:0];
         3'd3:    return (y == 4'd0) ? 4'hF : x / y;
         3'd4:    return x & y;
         3'd5:    return x | y;
         3'd6:    return x ^ y;
         default: return 4'hA;
      endcase
   endfunction

   assign ares[0] = ula(aop[0], aa[0], ab[0]);
   assign ares[1] = ula(aop[1], aa[1], ab[1]);

   ula_issue #(.ALU_LAT(1)) u1 (
      .CLOCK_27    (clk),
      .RST         (rst),
      .instr       (instr[0]),
      .instr_valid (vld[0]),
      .instr_ready (rdy[0]),
      .alu_op      (aop[0]),
      .alu_a       (aa[0]),
      .alu_b       (ab[0]),
      .alu_result  (ares[0]),
      .done        (dn[0]),
      .ovf         (ov[0]),
      .dz          (dzz[0]),
      .dbg_sel     (dsel[0]),
      .dbg_data    (ddat[0])
   );

   ula_issue #(.ALU_LAT(3)) u3 (
      .CLOCK_27    (clk),
      .RST         (rst),
      .instr       (instr[1]),
      .instr_valid (vld[1]),
      .instr_ready (rdy[1]),
      .alu_op      (aop[1]),
      .alu_a       (aa[1]),
      .alu_b       (ab[1]),
      .alu_result  (ares[1]),
      .done        (dn[1]),
      .ovf         (ov[1]),
      .dz          (dzz[1]),
      .dbg_sel     (dsel[1]),
      .dbg_data    (ddat[1])
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one instruction; return cycles from accept to the done
   // negedge, operands seen in the first EXEC cycle, and their stability.
   task automatic issue(input int d,
                        input logic [2:0] op,
                        input logic [2:0] rd,
                        input logic [2:0] ra,
                        input logic [2:0] rb,
                        output int lat,
                        output logic [2:0] a0,
                        output logic [2:0] b0,
                        output logic stab);
      int l;
      l = (d == 0) ? 1 : 3;
      @(negedge clk);
      instr[d] = {op, rd, ra, rb};
      vld[d]   = 1'b1;
      dsel[d]  = rd;
      @(posedge clk);
      #1;
      vld[d]   = 1'b0;
      instr[d] = 12'hFFF;
      lat  = 0;
      stab = 1'b1;
      a0   = '0;
      b0   = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) begin
            a0 = aa[d];
            b0 = ab[d];
         end else if (i > 2 && i <= l + 1) begin
            if (aa[d] !== a0 || ab[d] !== b0)
               stab = 1'b0;
         end
         if (dn[d]) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic ldi(input int d, input logic [2:0] rd,
                      input logic [2:0] imm, input string tag);
      int lat;
      logic [2:0] a0;
      logic [2:0] b0;
      logic st;
      issue(d, 3'd7, rd, imm, 3'd0, lat, a0, b0, st);
      check({tag, "_lat"}, lat, (d == 0) ? 4 : 6);
      check({tag, "_val"}, ddat[d], {29'd0, imm});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int nd;
      logic [2:0] a0;
      logic [2:0] b0;
      logic st;

      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         instr[d] = '0;
         vld[d]   = 1'b0;
         dsel[d]  = '0;
      end
      repeat (2) @(negedge clk);
      check("rst_ready", rdy[0], 1);
      check("rst_done", dn[0], 0);
      check("rst_ovf", ov[0], 0);
      check("rst_dz", dzz[0], 0);
      check("rst_aluop", aop[0], 0);
      check("rst_alua", aa[0], 0);
      check("rst_alub", ab[0], 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dsel[0] = 3'(i);
         #1;
         check("rst_reg", ddat[0], 0);
      end

      // LDI r1=5, LDI r2=6, ADD r3 = 11 -> r3=3, ovf=1
      ldi(0, 3'd1, 3'd5, "ldi_r1");
      ldi(0, 3'd2, 3'd6, "ldi_r2");
      issue(0, 3'd0, 3'd3, 3'd1, 3'd2, lat, a0, b0, st);
      check("add_lat", lat, 4);
      check("add_a", a0, 5);
      check("add_b", b0, 6);
      check("add_r3", ddat[0], 3);
      check("add_ovf", ov[0], 1);
      check("add_dz", dzz[0], 0);

      // SUB 2-5 -> 4'b1101: r4=5, ovf=1
      ldi(0, 3'd1, 3'd2, "ldi_r1b");
      ldi(0, 3'd2, 3'd5, "ldi_r2b");
      issue(0, 3'd1, 3'd4, 3'd1, 3'd2, lat, a0, b0, st);
      check("sub_r4", ddat[0], 5);
      check("sub_ovf", ov[0], 1);
      check("sub_dz", dzz[0], 0);

      // DIV 6/0 -> r5=7, dz=1; then AND r6=6&6
      ldi(0, 3'd1, 3'd6, "ldi_r1c");
      ldi(0, 3'd2, 3'd0, "ldi_r2c");
      issue(0, 3'd3, 3'd5, 3'd1, 3'd2, lat, a0, b0, st);
      check("div_lat", lat, 4);
      check("div_r5", ddat[0], 7);
      check("div_dz", dzz[0], 1);
      check("div_ovf", ov[0], 0);
      issue(0, 3'd4, 3'd6, 3'd1, 3'd1, lat, a0, b0, st);
      check("and_r6", ddat[0], 6);
      check("and_dz", dzz[0], 0);
      check("and_ovf", ov[0], 0);

      // Held valid, XOR r7 = 6^3 for 10 edges -> 3 accepts
      ldi(0, 3'd2, 3'd3, "ldi_r2d");
      @(negedge clk);
      instr[0] = {3'd6, 3'd7, 3'd1, 3'd2};
      dsel[0]  = 3'd7;
      vld[0]   = 1'b1;
      nd = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         if (i == 10) begin
            #1;
            vld[0] = 1'b0;
         end
         @(negedge clk);
         if (dn[0]) begin
            nd++;
            check("xor_r7", ddat[0], 5);
         end
      end
      check("xor_accepts", nd, 3);

      // Reset after edge A+2 of MUL r1=3*2 -> no write
      ldi(0, 3'd3, 3'd2, "ldi_r3");
      @(negedge clk);
      instr[0] = {3'd2, 3'd1, 3'd2, 3'd3};
      dsel[0]  = 3'd1;
      vld[0]   = 1'b1;
      nd = 0;
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      @(negedge clk);
      nd += int'(dn[0]);
      @(posedge clk);
      @(negedge clk);
      nd += int'(dn[0]);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      instr[0] = {3'd7, 3'd4, 3'd7, 3'd0};
      vld[0]   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         nd += int'(dn[0]);
      end
      check("rstmid_ready", rdy[0], 1);
      check("rstmid_alua", aa[0], 0);
      rst    = 1'b0;
      vld[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         nd += int'(dn[0]);
      end
      check("rstmid_nodone", nd, 0);
      check("rstmid_r1", ddat[0], 0);
      dsel[0] = 3'd4;
      #1;
      check("rstmid_r4", ddat[0], 0);
      check("rstmid_ready2", rdy[0], 1);
      ldi(0, 3'd2, 3'd4, "post_rst");

      // ALU_LAT=3: OR r0 = 4|1 -> 5, operands stable across EXEC
      ldi(1, 3'd1, 3'd4, "l3_r1");
      ldi(1, 3'd2, 3'd1, "l3_r2");
      issue(1, 3'd5, 3'd0, 3'd1, 3'd2, lat, a0, b0, st);
      check("or_lat", lat, 6);
      check("or_a", a0, 4);
      check("or_b", b0, 1);
      check("or_stable", st, 1);
      check("or_r0", ddat[1], 5);
      check("or_ovf", ov[1], 0);
      check("or_dz", dzz[1], 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ula_issue.md
# ula_issue

Register-bank and issue controller that sits directly upstream of the ULA stage. It accepts one 12-bit instruction at a time, reads two 3-bit operands from an internal 8-entry register bank, and drives the ULA operand/opcode inputs. After a fixed latency it captures the 4-bit ULA result and writes it back to the destination register. It converts the switch-driven ULA into a single-issue register-to-register datapath.

## Interface
- ALU_LAT, 1, cycles from ULA inputs being driven to `alu_result` being valid; legal range 1..4.
- CLOCK_27  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- instr  in  12  instruction: [11:9] op, [8:6] rd, [5:3] ra, [2:0] rb.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  high only in IDLE; accept = instr_valid & instr_ready at a rising edge.
- alu_op  out  3  opcode to ULA.
- alu_a  out  3  operand A to ULA.
- alu_b  out  3  operand B to ULA.
- alu_result  in  4  ULA result.
- done  out  1  one-cycle pulse: write-back completed.
- ovf  out  1  bit 3 of the last written 4-bit value.
- dz  out  1  last instruction was a divide by zero.
- dbg_sel  in  3  register index for debug read.
- dbg_data  out  3  combinational read of `reg[dbg_sel]`.

## Operation
- Register bank: 8 × 3-bit registers, r0..r7, all writable, no hardwired zero.
- Op encoding: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor (all executed by the ULA); 7 LDI.
- ALU-executed ops (0..6):
  - `alu_a = reg[ra]`, `alu_b = reg[rb]`, `alu_op = op`.
  - Write-back value is the 4-bit `alu_result`.
  - `rd` receives `alu_result[2:0]`; `ovf = alu_result[3]`.
  - Sub wraps mod 16, so `ovf` acts as a borrow.
- LDI (op 7):
  - Write-back value is `{1'b0, ra field}`, so `rd` receives the 3-bit immediate held in the ra field.
  - `ovf = 0`, `dz = 0`.
  - `alu_op = 7` is still driven; `alu_result` is ignored.
- Divide by zero (op 3 and `reg[rb] == 0`):
  - Write-back value is 4'b0111, so `rd` receives 3'b111.
  - `ovf = 0`, `dz = 1`; `alu_result` is ignored.
- `ovf`/`dz` are not sticky. Both are overwritten at every write-back.
- Operands are sampled at the READ→EXEC edge. `instr` is latched at the accept edge, so later changes on `instr` have no effect.
- `rd == ra` or `rd == rb` is legal: reads precede the write.

## Timing
- FSM states: IDLE → READ → EXEC → WB → IDLE.
- All instructions have the same latency. There is no early exit for LDI or divide by zero.
- Edge A (accept):
  - `instr` is latched; IDLE → READ.
  - `instr_ready` falls in the next cycle.
- Edge A+1:
  - READ → EXEC.
  - `alu_op`/`alu_a`/`alu_b` are registered and held until the next accept.
  - An internal counter loads ALU_LAT.
- Edge A+1+ALU_LAT: EXEC → WB.
- Edge A+2+ALU_LAT:
  - `alu_result` is sampled and `reg[rd]`, `ovf`, `dz` are written.
  - `done` = 1 for exactly one cycle; WB → IDLE; `instr_ready` = 1.
- Earliest next accept: edge A+3+ALU_LAT. Throughput is one instruction per 3+ALU_LAT cycles.
- `instr_valid` outside IDLE is ignored. A held-high `instr_valid` is accepted exactly once per IDLE entry.
- `dbg_data` reflects a write starting from the cycle after the write edge.
- Reset (asynchronous, at any state, including mid-instruction):
  - State = IDLE, all registers = 0.
  - `alu_op`/`alu_a`/`alu_b` = 0; `done` = 0, `ovf` = 0, `dz` = 0.
  - `instr_ready` = 1.
  - An in-flight instruction is discarded with no write.
  - No accept occurs on any edge while RST is high.

## Test plan
- LDI r1=5, LDI r2=6, ADD r3=r1+r2, with a bench ULA model at ALU_LAT=1 → `alu_a`=5 and `alu_b`=6 during EXEC; `dbg_data`(r3)=3, `ovf`=1; `done` pulses exactly 4 cycles after each accept edge.
- r1=2, r2=5, SUB r4=r1-r2 → `alu_result`=4'b1101; r4=5, `ovf`=1, `dz`=0.
- r1=6, r2=0, DIV r5=r1/r2 → r5=7, `dz`=1; the next instruction, AND r6=r1&r1, gives r6=6 and `dz`=0.
- Hold `instr_valid`=1 with a constant XOR r7=r1^r2 (r1=6, r2=3) for 10 cycles → exactly 3 accepts (3 `done` pulses); each write gives r7=5.
- Assert RST at edge A+2 of MUL r1=r2*r3 (r2=3, r3=2) → no write, r1=0, `done` never pulses; after release, `instr_ready`=1 and a new accept is taken.
- ALU_LAT=3, OR r0=r1|r2 (r1=4, r2=1) → write at edge A+5, r0=5; `alu_a`/`alu_b` are stable for all 3 EXEC cycles.
